// File: rtl/i2s_tx_if.sv
// i2s_tx_if: FIFO write-side bus between the register wrapper (master) and
// the I2S transmitter (slave). Carries the write strobe/data, the flush
// request and the FIFO status returned to software.
interface i2s_tx_if #(
    parameter int AW = 4
);
    logic          fifo_wr;
    logic [31:0]   fifo_wdata;
    logic          fifo_clr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_level;

    modport master (
        output fifo_wr, fifo_wdata, fifo_clr,
        input  fifo_full, fifo_empty, fifo_level
    );

    modport slave (
        input  fifo_wr, fifo_wdata, fifo_clr,
        output fifo_full, fifo_empty, fifo_level
    );
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: master-mode I2S / left-justified serial audio transmitter with a
// 2**AW x 32 sample FIFO. Generates sck/ws from clk, pops one word per slot
// and shifts it out MSB-first on sdo.
// Optional build macro I2S_TX_MONO_EN: when defined, mono=1 makes only the
// left slot pop and the right slot repeat the same word; when undefined the
// mono port is ignored and the block is always stereo.
module i2s_tx #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  sck_prescaler,
    input  logic [5:0]  sample_size,
    input  logic        left_justified,
    input  logic        mono,
    i2s_tx_if.slave     fifo,
    output logic        underrun,
    input  logic        underrun_clr,
    output logic        sck,
    output logic        ws,
    output logic        sdo
);
    localparam int DEPTH = 1 << AW;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [AW:0]   level_nxt;
    logic          full_q;
    logic          empty_q;

    logic [7:0]    presc;
    logic [4:0]    bit_ctr;
    logic [31:0]   shreg;
    logic          sck_q;
    logic          ws_q;
    logic          sdo_q;
    logic          bit_q;
    logic          lj_q;
    logic          underrun_q;

    logic          fall_edge;
    logic          slot_start;
    logic          pop_req;
    logic          pop_ok;
    logic          wr_ok;
    logic          fmt_lj;
    logic          lj_bit;
    logic [5:0]    size_eff;
    logic [5:0]    shamt;
    logic [31:0]   src_word;
    logic [31:0]   load_word;

    assign fall_edge  = en && (presc == 8'd0) && sck_q;
    assign slot_start = fall_edge && (bit_ctr == 5'd0);

`ifdef I2S_TX_MONO_EN
    logic        is_left;
    logic [31:0] hold_q;

    // Left slot is ws=0 for Philips I2S and ws=1 for left-justified.
    assign is_left  = ((~ws_q) == left_justified);
    assign pop_req  = slot_start && !(mono && !is_left);
    assign src_word = pop_req ? (pop_ok ? mem[rd_ptr] : 32'd0) : hold_q;

    // Remember the last popped word so a mono right slot can repeat it.
    always_ff @(posedge clk) begin
        if (rst)
            hold_q <= 32'd0;
        else if (pop_req)
            hold_q <= src_word;
    end
`else
    logic unused_mono;

    assign unused_mono = mono;
    assign pop_req     = slot_start;
    assign src_word    = pop_ok ? mem[rd_ptr] : 32'd0;
`endif

    // A flush in the pop cycle turns the pop into an underrun.
    assign pop_ok = pop_req && !empty_q && !fifo.fifo_clr;
    assign wr_ok  = fifo.fifo_wr && !full_q && !fifo.fifo_clr;

    assign size_eff  = (sample_size == 6'd0 || sample_size > 6'd32) ? 6'd32 : sample_size;
    assign shamt     = 6'd32 - size_eff;
    assign load_word = src_word << shamt;

    // Format is sampled at slot start and held for the rest of the slot.
    assign fmt_lj = slot_start ? left_justified : lj_q;
    // Bit a left-justified stream would emit on this falling edge.
    assign lj_bit = slot_start ? load_word[31] : shreg[31];

    // Next occupancy from the accepted write and the successful pop.
    always_comb begin
        level_nxt = level;
        if (wr_ok && !pop_ok)
            level_nxt = level + (AW+1)'(1);
        else if (!wr_ok && pop_ok)
            level_nxt = level - (AW+1)'(1);
    end

    // FIFO storage; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= fifo.fifo_wdata;
    end

    // FIFO pointers and registered status.
    always_ff @(posedge clk) begin
        if (rst || fifo.fifo_clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            level   <= level_nxt;
            full_q  <= (level_nxt == (AW+1)'(DEPTH));
            empty_q <= (level_nxt == '0);
        end
    end

    // SCK generation and serializer; everything after the prescaler moves
    // only on sck falling edges. The shift register is kept one bit ahead
    // of the word it was loaded with, so its MSB is always the next bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= 8'd0;
            sck_q   <= 1'b0;
            ws_q    <= 1'b1;
            sdo_q   <= 1'b0;
            bit_q   <= 1'b0;
            lj_q    <= 1'b0;
            bit_ctr <= 5'd0;
            shreg   <= 32'd0;
        end else begin
            if (en) begin
                if (presc == 8'd0) begin
                    presc <= sck_prescaler;
                    sck_q <= ~sck_q;
                end else begin
                    presc <= presc - 8'd1;
                end
            end
            if (fall_edge) begin
                bit_ctr <= bit_ctr + 5'd1;
                bit_q   <= lj_bit;
                sdo_q   <= fmt_lj ? lj_bit : bit_q;
                if (slot_start) begin
                    ws_q  <= ~ws_q;
                    lj_q  <= left_justified;
                    shreg <= load_word << 1;
                end else begin
                    shreg <= shreg << 1;
                end
            end
        end
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)
            underrun_q <= 1'b0;
        else if (pop_req && !pop_ok)
            underrun_q <= 1'b1;
        else if (underrun_clr)
            underrun_q <= 1'b0;
    end

    assign sck             = sck_q;
    assign ws              = ws_q;
    assign sdo             = sdo_q;
    assign underrun        = underrun_q;
    assign fifo.fifo_full  = full_q;
    assign fifo.fifo_empty = empty_q;
    assign fifo.fifo_level = level;
endmodule
